// File: rtl/timebase_controller.sv
// -----------------------------------------------------------------------------
// timebase_controller
// Scope timebase and capture sequencer. Generates the ADC sample strobe and a
// square-wave sample clock at a runtime-selectable rate (divisor MIN_DIV << i).
// It also sequences one capture into sample RAM: arm, wait for trigger, write
// CAPTURE_DEPTH samples, then report done.
//
// Optional feature macro: PRETRIGGER_EN
//   Defined   : ARMED writes on every tick into a circular buffer. The trigger
//               is accepted only after CAPTURE_DEPTH/2 ARMED writes.
//               CAPTURE then writes CAPTURE_DEPTH/2 - 1 further samples.
//   Undefined : no writes in ARMED. The trigger sample is the first write.
//
// Ports
//   i_clock          system clock
//   i_reset_n        asynchronous active-low reset
//   i_rate_up        pulse: request the next slower timebase
//   i_rate_down      pulse: request the next faster timebase
//   i_arm            pulse: start a capture (honoured in IDLE/DONE only)
//   i_trigger        trigger detector, sampled on sample ticks in ARMED only
//   o_sample_tick    one-cycle sample enable
//   o_sample_clock   square-wave ADC clock
//   o_rate_index     active timebase index
//   o_sample_addr    RAM write address
//   o_capture_we     RAM write enable (only ever high with o_sample_tick)
//   o_busy           high in ARMED or CAPTURE
//   o_done           capture complete
//   o_trigger_addr   RAM address of the trigger sample
//
// Assumes MIN_DIV >= 2 and CAPTURE_DEPTH >= 4 (power of two).
// -----------------------------------------------------------------------------
module timebase_controller #(
    parameter int unsigned MIN_DIV       = 50,
    parameter int unsigned NUM_RATES     = 8,
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned CAPTURE_DEPTH = 1024,
    parameter int unsigned ADDR_WIDTH    = 10
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_rate_up,
    input  logic                  i_rate_down,
    input  logic                  i_arm,
    input  logic                  i_trigger,
    output logic                  o_sample_tick,
    output logic                  o_sample_clock,
    output logic [2:0]            o_rate_index,
    output logic [ADDR_WIDTH-1:0] o_sample_addr,
    output logic                  o_capture_we,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_trigger_addr
);

    localparam int unsigned RATE_W = 3;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(NUM_RATES - 1);

`ifdef PRETRIGGER_EN
    // Writes in CAPTURE, counting the trigger write itself.
    localparam int unsigned POST_WRITES = CAPTURE_DEPTH / 2;
    // Pre-trigger writes required before a trigger is accepted.
    localparam int unsigned ARM_FILL    = CAPTURE_DEPTH / 2;
`else
    localparam int unsigned POST_WRITES = CAPTURE_DEPTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_UP   = 2'd1,
        P_DOWN = 2'd2
    } pend_t;

    // Timebase registers
    logic [DIV_WIDTH-1:0]  r_count;
    logic [RATE_W-1:0]     r_rate_index;
    pend_t                 r_pend;
    logic                  r_sample_tick;
    logic                  r_sample_clock;

    // Capture registers
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_sample_addr;
    logic [ADDR_WIDTH-1:0] r_trigger_addr;
    logic                  r_capture_we;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      r_wr_cnt;

    // Timebase wires
    logic [DIV_WIDTH-1:0]  w_div;
    logic [DIV_WIDTH-1:0]  w_half;
    logic                  w_wrap;
    logic                  w_rate_ok;

    // Next-state wires
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_taddr_nxt;
    logic                  w_we_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [CNT_W-1:0]      w_wr_cnt_nxt;

    // Divisor for the active rate; w_wrap marks the last count of a period,
    // i.e. the cycle whose closing edge raises o_sample_tick.
    assign w_div     = DIV_WIDTH'(MIN_DIV) << r_rate_index;
    assign w_half    = w_div >> 1;
    assign w_wrap    = (r_count == (w_div - DIV_WIDTH'(1)));
    assign w_rate_ok = (r_state == S_IDLE) || (r_state == S_DONE);

    // Period counter, tick and ADC clock
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count        <= '0;
            r_sample_tick  <= 1'b0;
            r_sample_clock <= 1'b0;
        end else begin
            r_count        <= w_wrap ? '0 : (r_count + DIV_WIDTH'(1));
            r_sample_tick  <= w_wrap;
            r_sample_clock <= (r_count < w_half);
        end
    end

    // Rate request capture and application. The request is applied on a wrap
    // edge, so the new divisor starts with a fresh count of 0 (no runt period).
    // A request arriving on the apply edge becomes the next pending one.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend       <= P_NONE;
            r_rate_index <= '0;
        end else begin
            if (i_rate_up && !i_rate_down) begin
                r_pend <= P_UP;
            end else if (i_rate_down && !i_rate_up) begin
                r_pend <= P_DOWN;
            end else if (w_wrap && w_rate_ok) begin
                r_pend <= P_NONE;
            end

            if (w_wrap && w_rate_ok) begin
                if ((r_pend == P_UP) && (r_rate_index != RATE_MAX)) begin
                    r_rate_index <= r_rate_index + RATE_W'(1);
                end else if ((r_pend == P_DOWN) && (r_rate_index != '0)) begin
                    r_rate_index <= r_rate_index - RATE_W'(1);
                end
            end
        end
    end

    // Capture FSM state and registered outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_sample_addr  <= '0;
            r_trigger_addr <= '0;
            r_capture_we   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_wr_cnt       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sample_addr  <= w_addr_nxt;
            r_trigger_addr <= w_taddr_nxt;
            r_capture_we   <= w_we_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_wr_cnt       <= w_wr_cnt_nxt;
        end
    end

    // Capture FSM next state. Write decisions use w_wrap so that capture_we is
    // registered on the same edge as sample_tick; the address advances on the
    // edge after a write so the RAM sees a stable address during the write.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_sample_addr;
        w_taddr_nxt  = r_trigger_addr;
        w_we_nxt     = 1'b0;
        w_done_nxt   = r_done;
        w_wr_cnt_nxt = r_wr_cnt;

        if (r_capture_we) begin
            w_addr_nxt = r_sample_addr + ADDR_WIDTH'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_state_nxt  = S_ARMED;
                    w_addr_nxt   = '0;
                    w_done_nxt   = 1'b0;
                    w_wr_cnt_nxt = '0;
                end
            end

            S_ARMED: begin
                if (w_wrap) begin
`ifdef PRETRIGGER_EN
                    w_we_nxt = 1'b1;
                    if (i_trigger && (r_wr_cnt == CNT_W'(ARM_FILL))) begin
                        w_taddr_nxt  = r_sample_addr;
                        w_wr_cnt_nxt = CNT_W'(1);
                        w_state_nxt  = S_CAPTURE;
                    end else if (r_wr_cnt != CNT_W'(ARM_FILL)) begin
                        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                    end
`else
                    if (i_trigger) begin
                        w_we_nxt     = 1'b1;
                        w_taddr_nxt  = r_sample_addr;
                        w_wr_cnt_nxt = CNT_W'(1);
                        w_state_nxt  = S_CAPTURE;
                    end
`endif
                end
            end

            S_CAPTURE: begin
                if (w_wrap) begin
                    w_we_nxt     = 1'b1;
                    w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                    if ((r_wr_cnt + CNT_W'(1)) == CNT_W'(POST_WRITES)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (i_arm) begin
                    w_state_nxt  = S_ARMED;
                    w_addr_nxt   = '0;
                    w_done_nxt   = 1'b0;
                    w_wr_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
    end

    assign o_sample_tick  = r_sample_tick;
    assign o_sample_clock = r_sample_clock;
    assign o_rate_index   = r_rate_index;
    assign o_sample_addr  = r_sample_addr;
    assign o_capture_we   = r_capture_we;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_trigger_addr = r_trigger_addr;

endmodule

// File: doc/timebase_controller.md
Name: timebase_controller

Overview:
Scope timebase and capture sequencer. Generates the ADC sample strobe and sample clock at a runtime-selectable rate. Sequences one capture into sample RAM: arm, wait for trigger, write CAPTURE_DEPTH samples, then report done. Sits between the front-panel/trigger logic and the ADC interface and sample RAM.

Parameters:
MIN_DIV, 50, clock divisor at rate index 0 (50 MHz / 50 = 1 MHz sampling); must be >= 2.
NUM_RATES, 8, number of timebase steps; divisor at index i = MIN_DIV << i.
DIV_WIDTH, 16, counter width; must hold (MIN_DIV << (NUM_RATES-1)) - 1.
CAPTURE_DEPTH, 1024, samples per capture; power of two.
ADDR_WIDTH, 10, log2(CAPTURE_DEPTH).

Ports:
clock  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
rate_up  in  1  single-cycle pulse, debounced: next slower timebase
rate_down  in  1  single-cycle pulse, debounced: next faster timebase
arm  in  1  single-cycle pulse: start a capture
trigger  in  1  trigger-detector output, sampled only on sample_tick
sample_tick  out  1  one-cycle sample enable
sample_clock  out  1  square-wave ADC clock
rate_index  out  3  active timebase index
sample_addr  out  ADDR_WIDTH  RAM write address
capture_we  out  1  RAM write enable
busy  out  1  high in ARMED or CAPTURE
done  out  1  capture complete
trigger_addr  out  ADDR_WIDTH  address of the trigger sample

Behaviour:
- Clock: one clock, `clock`. Reset: `reset_n` is asynchronous and active-low. Assertion clears all state immediately, including mid-capture.
- Reset values: counter 0, rate_index 0, state IDLE, pending request none. sample_tick 0, sample_clock 0, sample_addr 0, capture_we 0, busy 0, done 0, trigger_addr 0.
- Divisor: div = MIN_DIV << rate_index.
- Counter: counts 0..div-1 and wraps to 0.
- sample_tick: registered. High for exactly one cycle after the counter equals div-1. The first tick is at the div-th rising edge after reset release, then one every div cycles.
- sample_clock: registered. High while counter < div/2 (integer division), low otherwise.
- Rate requests:
  - rate_up sets pending +1; rate_down sets pending -1.
  - Both in the same cycle cancel each other. A new request overwrites an older pending one.
  - Pending is applied only on a wrap cycle (counter == div-1), and only in state IDLE or DONE. In ARMED or CAPTURE it is held.
  - Saturate at 0 and NUM_RATES-1. A request at a limit is discarded.
  - The new divisor takes effect from the counter's next 0, so there is no runt period.
- State machine, 2-bit: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: on arm go to ARMED; sample_addr <= 0, done <= 0.
  - ARMED: on sample_tick with trigger == 1, write the trigger sample: capture_we = 1 for that cycle, trigger_addr <= sample_addr. Then go to CAPTURE.
  - CAPTURE:
    - capture_we equals sample_tick.
    - sample_addr increments by 1 after each write and wraps modulo CAPTURE_DEPTH.
    - When CAPTURE_DEPTH writes have completed, including the trigger write, go to DONE; done <= 1 on the same edge.
  - DONE: done held high. On arm go to ARMED; done <= 0, sample_addr <= 0.
- arm is ignored in ARMED and CAPTURE.
- trigger is ignored outside ARMED and on non-tick cycles.
- busy = (state == ARMED) or (state == CAPTURE), registered.
- capture_we is never high without sample_tick. Only one write happens per tick.

Optional Feature:
PRETRIGGER_EN
- Defined:
  - In ARMED, every sample_tick writes, and sample_addr wraps circularly.
  - The trigger sample's address is latched in trigger_addr.
  - CAPTURE then writes CAPTURE_DEPTH/2 - 1 further samples, so the buffer holds half pre-trigger and half post-trigger data.
  - If the trigger arrives before CAPTURE_DEPTH/2 samples have been written in ARMED, it is ignored.
- Undefined: behaviour exactly as above, with no writes in ARMED.

Test Plan:
MIN_DIV=4, CAPTURE_DEPTH=8, ADDR_WIDTH=3 for all.
1. Release reset, idle 40 cycles -> sample_tick at cycles 4, 8, 12, …. sample_clock high 2 / low 2. rate_index 0.
2. rate_up pulse at cycle 5 -> rate_index 1 on the cycle-8 wrap. Ticks then every 8 cycles. sample_clock high 4 / low 4. rate_down ×3 -> saturates at 0.
3. Simultaneous rate_up and rate_down -> no change. rate_up while busy -> applied only after DONE, at the next wrap.
4. arm, trigger=1 from the 3rd tick on -> trigger_addr 0. Exactly 8 writes at addr 0..7, one per tick. done=1 after the 8th write. busy low. Further ticks produce no writes.
5. Assert reset_n low mid-CAPTURE at addr 5 -> all outputs return to reset values asynchronously. No writes after release until arm.
6. PRETRIGGER_EN, arm, trigger high from tick 2 -> trigger ignored until 4 ARMED writes. Trigger accepted at tick 5: trigger_addr 4, then 3 more writes at addr 5, 6, 7, then done.
